// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: both request ports, their grants and
// their read responses. The requesters drive the master modport and the
// arbiter takes the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port byte
// memory. Port 0 is instruction fetch, port 1 is load/store. One transaction
// at a time: grant in IDLE, one ISSUE cycle, then READ_LAT WAIT cycles for
// reads before the data is returned with a one-cycle rvalid pulse.
module mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // WAIT counter preload; READ_LAT=0 never enters WAIT so the value is unused.
  localparam logic [2:0] LAT_M1 = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

  logic [1:0]        state;
  logic              last_gnt;
  logic              id;
  logic              we_l;
  logic [2:0]        cnt;
  logic              gnt0;
  logic              gnt1;
  logic              capture;
  logic              rvalid0_r;
  logic              rvalid1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  // Grant only in IDLE; on a tie the port that did not win last time goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == S_IDLE) begin
      if (bus.req0 && (!bus.req1 || last_gnt)) gnt0 = 1'b1;
      else if (bus.req1)                       gnt1 = 1'b1;
    end
  end

  // Read data is taken from the memory at the end of the last latency cycle.
  always_comb begin
    capture = 1'b0;
    if (state == S_ISSUE && !we_l && READ_LAT == 0) capture = 1'b1;
    if (state == S_WAIT && cnt == 3'd0)             capture = 1'b1;
  end

  // Sequencer: latches the granted request straight into the memory pin
  // registers so they present it during ISSUE and hold it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last_gnt <= 1'b1;
      id       <= 1'b0;
      we_l     <= 1'b0;
      cnt      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_in   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            id       <= gnt1;
            last_gnt <= gnt1;
            we_l     <= gnt1 ? bus.we1    : bus.we0;
            mem_we   <= gnt1 ? bus.we1    : bus.we0;
            mem_addr <= gnt1 ? bus.addr1  : bus.addr0;
            mem_in   <= gnt1 ? bus.wdata1 : bus.wdata0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_we <= 1'b0;
          if (we_l || READ_LAT == 0) begin
            state <= S_IDLE;
          end else begin
            cnt   <= LAT_M1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_IDLE;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read response registers: one-cycle valid pulse, data held until the next
  // read completes on the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= capture && !id;
      rvalid1_r <= capture && id;
      if (capture && !id) rdata0_r <= mem_out;
      if (capture && id)  rdata1_r <= mem_out;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_r;
  assign bus.rvalid1 = rvalid1_r;
  assign bus.rdata0  = rdata0_r;
  assign bus.rdata1  = rdata1_r;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three builds (READ_LAT 1, 0, 3), each
// with a behavioural byte memory of matching read latency.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifa ();
  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifb ();
  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) ifc ();

  logic        a_busy, a_we, b_busy, b_we, c_busy, c_we;
  logic [11:0] a_addr, b_addr, c_addr;
  logic [7:0]  a_in, a_out, b_in, b_out, c_in, c_out;

  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(a_busy), .mem_we(a_we),
    .mem_addr(a_addr), .mem_in(a_in), .mem_out(a_out));
  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .busy(b_busy), .mem_we(b_we),
    .mem_addr(b_addr), .mem_in(b_in), .mem_out(b_out));
  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LAT(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .busy(c_busy), .mem_we(c_we),
    .mem_addr(c_addr), .mem_in(c_in), .mem_out(c_out));

  // Memories: A registered read (1 cycle), B combinational, C 3-stage.
  logic [7:0] ma [4096];
  logic [7:0] mb [4096];
  logic [7:0] mc [4096];
  logic [7:0] pa;
  logic [7:0] pc [3];

  always @(posedge clk) begin
    if (a_we) ma[a_addr] <= a_in;
    pa <= ma[a_addr];
  end
  assign a_out = pa;

  always @(posedge clk) if (b_we) mb[b_addr] <= b_in;
  assign b_out = mb[b_addr];

  always @(posedge clk) begin
    if (c_we) mc[c_addr] <= c_in;
    pc[0] <= mc[c_addr];
    pc[1] <= pc[0];
    pc[2] <= pc[1];
  end
  assign c_out = pc[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
  endtask

  task automatic do_reset;
    clr();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_a(input int port, input logic we, input logic [11:0] ad,
                       input logic [7:0] d);
    if (port == 0) begin
      ifa.req0 = 1'b1; ifa.we0 = we; ifa.addr0 = ad; ifa.wdata0 = d;
    end else begin
      ifa.req1 = 1'b1; ifa.we1 = we; ifa.addr1 = ad; ifa.wdata1 = d;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", a_busy); end
    n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %0b want 0", a_we); end
    n_cmp++; if (a_addr !== 12'h000) begin n_err++; $display("FAIL rst_mem_addr: got %h want 000", a_addr); end
    n_cmp++; if (a_in !== 8'h00) begin n_err++; $display("FAIL rst_mem_in: got %h want 00", a_in); end
    n_cmp++; if ({ifa.rvalid0, ifa.rvalid1} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {ifa.rvalid0, ifa.rvalid1}); end
    n_cmp++; if ({ifa.rdata0, ifa.rdata1} !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", {ifa.rdata0, ifa.rdata1}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read;
    // write 0x3FF = 0xA3 on port 0
    set_a(0, 1'b1, 12'h3FF, 8'hA3);
    #3;
    n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", {ifa.gnt0, ifa.gnt1}); end
    tick(); clr(); #3;
    n_cmp++; if (a_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %0b want 1", a_we); end
    n_cmp++; if (a_addr !== 12'h3FF) begin n_err++; $display("FAIL wr_mem_addr: got %h want 3ff", a_addr); end
    n_cmp++; if (a_in !== 8'hA3) begin n_err++; $display("FAIL wr_mem_in: got %h want a3", a_in); end
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %0b want 1", a_busy); end
    tick();
    // read it back: gnt cycle 0, rvalid cycle 3
    set_a(0, 1'b0, 12'h3FF, 8'h00);
    #3;
    n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL wr_we_once: got %0b want 0", a_we); end
    n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== 2'b10) begin n_err++; $display("FAIL rd_gnt: got %b want 10", {ifa.gnt0, ifa.gnt1}); end
    tick(); clr(); #3;
    n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL rd_issue_we: got %0b want 0", a_we); end
    tick(); #3;
    n_cmp++; if (ifa.rvalid0 !== 1'b0) begin n_err++; $display("FAIL rd_early: got %0b want 0", ifa.rvalid0); end
    tick(); #3;
    n_cmp++; if (ifa.rvalid0 !== 1'b1) begin n_err++; $display("FAIL rd_rvalid0: got %0b want 1", ifa.rvalid0); end
    n_cmp++; if (ifa.rdata0 !== 8'hA3) begin n_err++; $display("FAIL rd_rdata0: got %h want a3", ifa.rdata0); end
    n_cmp++; if (ifa.rvalid1 !== 1'b0) begin n_err++; $display("FAIL rd_rvalid1: got %0b want 0", ifa.rvalid1); end
    tick(); #3;
    n_cmp++; if (ifa.rvalid0 !== 1'b0) begin n_err++; $display("FAIL rd_pulse: got %0b want 0", ifa.rvalid0); end
    n_cmp++; if (ifa.rdata0 !== 8'hA3) begin n_err++; $display("FAIL rd_hold: got %h want a3", ifa.rdata0); end
    tick();
  endtask

  task automatic test_fill_readback;
    logic [11:0] ad [4];
    logic [7:0]  dt [4];
    ad = '{12'h000, 12'h400, 12'h800, 12'hC00};
    dt = '{8'hA1, 8'hB1, 8'hC1, 8'hD1};
    for (int i = 0; i < 4; i++) begin
      set_a(1, 1'b1, ad[i], dt[i]);
      #3;
      n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== 2'b01) begin n_err++; $display("FAIL fill_gnt%0d: got %b want 01", i, {ifa.gnt0, ifa.gnt1}); end
      tick(); clr(); #3;
      n_cmp++; if ({a_we, a_addr, a_in} !== {1'b1, ad[i], dt[i]}) begin n_err++; $display("FAIL fill_pins%0d: got %h want %h", i, {a_we, a_addr, a_in}, {1'b1, ad[i], dt[i]}); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_a(0, 1'b0, ad[i], 8'h00);
      #3;
      n_cmp++; if (ifa.gnt0 !== 1'b1) begin n_err++; $display("FAIL back_gnt%0d: got %0b want 1", i, ifa.gnt0); end
      tick(); clr(); tick(); tick(); #3;
      n_cmp++; if ({ifa.rvalid0, ifa.rdata0} !== {1'b1, dt[i]}) begin n_err++; $display("FAIL back_data%0d: got %h want %h", i, {ifa.rvalid0, ifa.rdata0}, {1'b1, dt[i]}); end
      tick();
    end
  endtask

  task automatic test_round_robin;
    logic exp0;
    do_reset();
    set_a(0, 1'b0, 12'h3FF, 8'h00);
    set_a(1, 1'b0, 12'h400, 8'h00);
    for (int k = 0; k < 4; k++) begin
      exp0 = (k % 2 == 0);
      #3;
      n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== {exp0, !exp0}) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", k, {ifa.gnt0, ifa.gnt1}, {exp0, !exp0}); end
      if (k > 0) begin
        if (exp0) begin
          n_cmp++; if ({ifa.rvalid1, ifa.rdata1} !== {1'b1, 8'hB1}) begin n_err++; $display("FAIL rr_resp%0d: got %h want 1b1", k, {ifa.rvalid1, ifa.rdata1}); end
        end else begin
          n_cmp++; if ({ifa.rvalid0, ifa.rdata0} !== {1'b1, 8'hA3}) begin n_err++; $display("FAIL rr_resp%0d: got %h want 1a3", k, {ifa.rvalid0, ifa.rdata0}); end
        end
      end
      tick();
      if (k == 3) clr();
      tick(); tick();
    end
    #3;
    n_cmp++; if ({ifa.rvalid1, ifa.rdata1} !== {1'b1, 8'hB1}) begin n_err++; $display("FAIL rr_last: got %h want 1b1", {ifa.rvalid1, ifa.rdata1}); end
    tick();
  endtask

  task automatic test_same_addr;
    do_reset();
    set_a(0, 1'b1, 12'h7FF, 8'hB3);
    set_a(1, 1'b0, 12'h7FF, 8'h00);
    #3;
    n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== 2'b10) begin n_err++; $display("FAIL same_gnt_first: got %b want 10", {ifa.gnt0, ifa.gnt1}); end
    tick(); ifa.req0 = 1'b0; #3;
    n_cmp++; if ({a_we, a_addr, a_in} !== {1'b1, 12'h7FF, 8'hB3}) begin n_err++; $display("FAIL same_wr_pins: got %h want 17ffb3", {a_we, a_addr, a_in}); end
    n_cmp++; if (ifa.gnt1 !== 1'b0) begin n_err++; $display("FAIL same_gnt_busy: got %0b want 0", ifa.gnt1); end
    tick(); #3;
    n_cmp++; if ({ifa.gnt0, ifa.gnt1} !== 2'b01) begin n_err++; $display("FAIL same_gnt_second: got %b want 01", {ifa.gnt0, ifa.gnt1}); end
    tick(); clr(); tick(); tick(); #3;
    n_cmp++; if ({ifa.rvalid1, ifa.rdata1} !== {1'b1, 8'hB3}) begin n_err++; $display("FAIL same_rdata1: got %h want 1b3", {ifa.rvalid1, ifa.rdata1}); end
    n_cmp++; if (ifa.rvalid0 !== 1'b0) begin n_err++; $display("FAIL same_rvalid0: got %0b want 0", ifa.rvalid0); end
    tick();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    set_a(0, 1'b0, 12'h000, 8'h00);
    tick(); clr(); tick(); #3;
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_wait: got %0b want 1", a_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({a_busy, a_we, ifa.rvalid0, ifa.rvalid1} !== 4'b0000) begin n_err++; $display("FAIL mid_async: got %b want 0000", {a_busy, a_we, ifa.rvalid0, ifa.rvalid1}); end
    n_cmp++; if ({a_addr, ifa.rdata0} !== 20'h00000) begin n_err++; $display("FAIL mid_clear: got %h want 00000", {a_addr, ifa.rdata0}); end
    tick(); #3;
    n_cmp++; if ({ifa.rvalid0, ifa.rvalid1, a_busy} !== 3'b000) begin n_err++; $display("FAIL mid_no_resp: got %b want 000", {ifa.rvalid0, ifa.rvalid1, a_busy}); end
    tick();
    rst_n = 1'b1;
    set_a(0, 1'b0, 12'h800, 8'h00);
    #3;
    n_cmp++; if (ifa.gnt0 !== 1'b1) begin n_err++; $display("FAIL mid_regnt: got %0b want 1", ifa.gnt0); end
    tick(); clr(); tick(); tick(); #3;
    n_cmp++; if ({ifa.rvalid0, ifa.rdata0} !== {1'b1, 8'hC1}) begin n_err++; $display("FAIL mid_reread: got %h want 1c1", {ifa.rvalid0, ifa.rdata0}); end
    tick();
  endtask

  task automatic test_latency;
    do_reset();
    ifb.req0 = 1'b1; ifb.we0 = 1'b1; ifb.addr0 = 12'h123; ifb.wdata0 = 8'h5A;
    ifc.req0 = 1'b1; ifc.we0 = 1'b1; ifc.addr0 = 12'h123; ifc.wdata0 = 8'h6B;
    #3;
    n_cmp++; if ({ifb.gnt0, ifc.gnt0} !== 2'b11) begin n_err++; $display("FAIL lat_wr_gnt: got %b want 11", {ifb.gnt0, ifc.gnt0}); end
    tick(); clr(); tick();
    ifb.req0 = 1'b1; ifb.we0 = 1'b0;
    ifc.req0 = 1'b1; ifc.we0 = 1'b0;
    #3;
    n_cmp++; if ({ifb.gnt0, ifc.gnt0} !== 2'b11) begin n_err++; $display("FAIL lat_rd_gnt: got %b want 11", {ifb.gnt0, ifc.gnt0}); end
    tick();
    clr();
    for (int k = 1; k <= 6; k++) begin
      #3;
      n_cmp++; if (ifb.rvalid0 !== (k == 2)) begin n_err++; $display("FAIL lat0_rvalid_c%0d: got %0b want %0b", k, ifb.rvalid0, (k == 2)); end
      n_cmp++; if (ifc.rvalid0 !== (k == 5)) begin n_err++; $display("FAIL lat3_rvalid_c%0d: got %0b want %0b", k, ifc.rvalid0, (k == 5)); end
      if (k == 2) begin
        n_cmp++; if (ifb.rdata0 !== 8'h5A) begin n_err++; $display("FAIL lat0_rdata: got %h want 5a", ifb.rdata0); end
      end
      if (k == 5) begin
        n_cmp++; if (ifc.rdata0 !== 8'h6B) begin n_err++; $display("FAIL lat3_rdata: got %h want 6b", ifc.rdata0); end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.we0 = 1'b0; ifa.we1 = 1'b0;
    ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.we0 = 1'b0; ifb.we1 = 1'b0;
    ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0;
    ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.we0 = 1'b0; ifc.we1 = 1'b0;
    ifc.addr0 = '0; ifc.addr1 = '0; ifc.wdata0 = '0; ifc.wdata1 = '0;
    test_reset();
    test_write_read();
    test_fill_readback();
    test_round_robin();
    test_same_addr();
    test_reset_mid_read();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
